s3_writeback: RTL and testbench
===============================

Name: s3_writeback

Overview:
- Stage-3 (memory/writeback) datapath of the 3-stage RV32I core.
- Registers the stage-2 results at the s2/s3 boundary and selects load data from DMEM, BIOS or memory-mapped IO.
- Performs byte/half extraction and the writeback mux, then drives the regfile write port and the s3->s2 forwarding path.
- Owns the cycle and retired-instruction performance counters.

Parameters:
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) inserted on reset/flush
- CNT_W, 32, width of the cycle and instruction counters

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all s3 state this cycle
- flush  in  1  load a bubble into s3 instead of the s2 instruction
- instr_s2  in  32  instruction leaving stage 2
- alu_s2  in  32  ALU result / memory address from stage 2
- pc4_s2  in  32  PC+4 of the stage-2 instruction
- dmem_dout  in  32  DMEM synchronous read data (address presented in s2)
- bios_dout  in  32  BIOS port-B synchronous read data
- uart_rx_data  in  8  UART receive byte
- uart_rx_valid  in  1  UART receive data valid
- uart_tx_ready  in  1  UART transmitter ready
- instr_s3  out  32  registered stage-3 instruction (consumed by s3 control)
- wb_data  out  32  writeback / forwarding data
- wb_rd  out  5  destination register, instr_s3[11:7]
- wb_we  out  1  regfile write enable
- cycle_cnt  out  CNT_W  cycle counter
- inst_cnt  out  CNT_W  retired-instruction counter

Behaviour:
- Pipeline register: on each clk edge, with priority rst > flush > stall > normal:
  - rst or flush: instr_s3 <= NOP_INSTR; valid_s3 <= 0; alu/pc4 regs <= 0.
  - stall: all s3 registers hold.
  - normal: capture instr_s2, alu_s2 and pc4_s2; set valid_s3 <= 1.
- IO read capture: on the same enable, latch io_rdata from alu_s2 so it aligns with the synchronous memory reads:
  - 0x8000_0000 -> {30'b0, uart_rx_valid, uart_tx_ready}
  - 0x8000_0004 -> {24'b0, uart_rx_data}
  - 0x8000_0010 -> cycle_cnt
  - 0x8000_0014 -> inst_cnt
  - any other IO address -> 0
- Load source, by alu_s3[31:28]:
  - 4'b0001 or 4'b0011 -> dmem_dout
  - 4'b0100 -> bios_dout
  - 4'b1000 -> io_rdata
  - anything else -> 0
- Load extraction, by func3 (instr_s3[14:12]) and alu_s3[1:0]:
  - LB/LBU: select byte addr[1:0], then sign- or zero-extend.
  - LH/LHU: select halfword addr[1] (addr[0] ignored), then sign- or zero-extend.
  - LW: ignore addr[1:0].
  - Undefined func3: word unchanged.
- Writeback select, decoded from opcode instr_s3[6:2]:
  - LOAD -> 0, extracted load data.
  - JAL, JALR -> 2, pc4_s3.
  - All others -> 1, alu_s3.
- Write enable: wb_we = valid_s3 && rd != 0 && opcode ∈ {LUI, AUIPC, JAL, JALR, LOAD, ARI_RTYPE, ARI_ITYPE, 5'b11100}. It is 0 for BRANCH, STORE and any unknown opcode.
- Combinational timing: wb_data and wb_we are combinational from s3 registers and memory outputs.
  - Zero added latency: an instruction is written back in the cycle after it leaves s2.
  - During stall the same write repeats, which is idempotent.
- cycle_cnt:
  - Increments by 1 every cycle when not in rst, including stall cycles.
  - Wraps at 2^CNT_W.
- inst_cnt:
  - Increments when valid_s3 && !stall, so each non-bubble retires exactly once.
  - Wraps at 2^CNT_W.
- Counter reset:
  - A STORE in s2 with alu_s2 == 0x8000_0018, not stalled or flushed, clears both counters on that edge.
  - The clear beats a simultaneous increment: both counters read 0 in the next cycle.
- Reset values:
  - instr_s3 = NOP_INSTR.
  - wb_we = 0, wb_rd = 0, wb_data = 0 (alu reg 0).
  - cycle_cnt = 0, inst_cnt = 0.
- Reset asserted mid-stall: it overrides the stall, and the held instruction is discarded without retiring.

Decomposition:
- Shared header: reuse the OPC_*_5 and FNC_* constants.
- Add an address-map include with the region nibbles and IO offsets (UART_CTRL, UART_RX, CYCLE_CNT, INST_CNT, CNT_RST).
- One natural sub-module: load_extract, purely combinational, taking (word, addr[1:0], func3) -> data.

Test Plan:
- Reset, then release with no instructions: instr_s3 = 0x00000013, wb_we = 0, cycle_cnt counts 1, 2, 3, and inst_cnt stays 0 because bubbles do not count.
- LB x5 from 0x1000_0003 with dmem_dout = 0x80FF_1234: wb_data = 0xFFFF_FF80, wb_rd = 5, wb_we = 1. LBU from the same address gives 0x0000_0080. LHU from 0x1000_0002 gives 0x0000_80FF.
- JAL x1 with pc4_s2 = 0x4000_0104: the next cycle shows wb_data = 0x4000_0104 and wb_we = 1. ADDI x0 gives wb_we = 0. SW gives wb_we = 0.
- LW from 0x8000_0000 with uart_rx_valid = 1 and uart_tx_ready = 0 gives wb_data = 2. LW from 0x8000_0010 returns the cycle_cnt value sampled at the s2/s3 edge.
- Issue 3 valid instructions, then stall for 2 cycles, then flush for 1 cycle: inst_cnt = 3 and cycle_cnt advances by 6. After the flush, instr_s3 = NOP.
- Set cycle_cnt = 0xFFFF_FFFF via a long run or force: it wraps to 0. Then SW to 0x8000_0018: both counters read 0 in the following cycle, even while an instruction retires in that cycle.

Source files
------------

// File: rtl/s3_writeback_pkg.sv
// Shared constants for the stage-3 writeback slice: opcodes, load func3
// codes, the address-region nibbles and the memory-mapped IO offsets.
package s3_writeback_pkg;

  localparam logic [4:0] OPC_LUI_5       = 5'b01101;
  localparam logic [4:0] OPC_AUIPC_5     = 5'b00101;
  localparam logic [4:0] OPC_JAL_5       = 5'b11011;
  localparam logic [4:0] OPC_JALR_5      = 5'b11001;
  localparam logic [4:0] OPC_BRANCH_5    = 5'b11000;
  localparam logic [4:0] OPC_STORE_5     = 5'b01000;
  localparam logic [4:0] OPC_LOAD_5      = 5'b00000;
  localparam logic [4:0] OPC_ARI_RTYPE_5 = 5'b01100;
  localparam logic [4:0] OPC_ARI_ITYPE_5 = 5'b00100;
  localparam logic [4:0] OPC_CSR_5       = 5'b11100;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  localparam logic [3:0] REG_DMEM_A = 4'b0001;
  localparam logic [3:0] REG_DMEM_B = 4'b0011;
  localparam logic [3:0] REG_BIOS   = 4'b0100;
  localparam logic [3:0] REG_IO     = 4'b1000;

  localparam logic [31:0] IO_UART_CTRL = 32'h8000_0000;
  localparam logic [31:0] IO_UART_RX   = 32'h8000_0004;
  localparam logic [31:0] IO_CYCLE_CNT = 32'h8000_0010;
  localparam logic [31:0] IO_INST_CNT  = 32'h8000_0014;
  localparam logic [31:0] IO_CNT_RST   = 32'h8000_0018;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  function automatic logic opc_writes_rd(input logic [4:0] opc);
    unique case (opc)
      OPC_LUI_5, OPC_AUIPC_5, OPC_JAL_5, OPC_JALR_5,
      OPC_LOAD_5, OPC_ARI_RTYPE_5, OPC_ARI_ITYPE_5,
      OPC_CSR_5: opc_writes_rd = 1'b1;
      default:   opc_writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/s3_writeback_if.sv
// Stage-3 bus: s2 results, memory/UART read data in, writeback
// port and performance counters out.
interface s3_writeback_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             flush;
  logic [31:0]      instr_s2;
  logic [31:0]      alu_s2;
  logic [31:0]      pc4_s2;
  logic [31:0]      dmem_dout;
  logic [31:0]      bios_dout;
  logic [7:0]       uart_rx_data;
  logic             uart_rx_valid;
  logic             uart_tx_ready;
  logic [31:0]      instr_s3;
  logic [31:0]      wb_data;
  logic [4:0]       wb_rd;
  logic             wb_we;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] inst_cnt;

  modport master (
    output stall, flush, instr_s2, alu_s2, pc4_s2,
    output dmem_dout, bios_dout,
    output uart_rx_data, uart_rx_valid, uart_tx_ready,
    input  instr_s3, wb_data, wb_rd, wb_we,
    input  cycle_cnt, inst_cnt
  );

  modport slave (
    input  stall, flush, instr_s2, alu_s2, pc4_s2,
    input  dmem_dout, bios_dout,
    input  uart_rx_data, uart_rx_valid, uart_tx_ready,
    output instr_s3, wb_data, wb_rd, wb_we,
    output cycle_cnt, inst_cnt
  );
endinterface

// File: rtl/s3_writeback_load_extract.sv
// Byte/half/word extraction with sign or zero extension for loads.
module s3_writeback_load_extract
  import s3_writeback_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    unique case (addr_i)
      2'd0:    byte_w = word_i[7:0];
      2'd1:    byte_w = word_i[15:8];
      2'd2:    byte_w = word_i[23:16];
      default: byte_w = word_i[31:24];
    endcase
    half_w = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    unique case (func3_i)
      FNC_LB:  data_o = {{24{byte_w[7]}}, byte_w};
      FNC_LBU: data_o = {24'b0, byte_w};
      FNC_LH:  data_o = {{16{half_w[15]}}, half_w};
      FNC_LHU: data_o = {16'b0, half_w};
      FNC_LW:  data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/s3_writeback.sv
// Stage-3 memory/writeback: s2/s3 pipeline register, load source mux,
// writeback mux, regfile write port and cycle/instret counters.
module s3_writeback
  import s3_writeback_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic clk,
  input  logic rst,
  s3_writeback_if.slave wb
);

  logic [31:0]      instr_q, instr_d;
  logic [31:0]      alu_q, alu_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [31:0]      io_q, io_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] inst_q, inst_d;

  logic        advance;
  logic        cnt_clr;
  logic        retire;
  logic [31:0] io_sel;
  logic [31:0] ld_word;
  logic [31:0] ld_data;
  logic [4:0]  opc;
  logic [4:0]  rd;
  wb_sel_t     wb_sel;

  assign advance = !wb.stall && !wb.flush;
  assign retire  = valid_q && !wb.stall;
  assign cnt_clr = advance
                && (wb.instr_s2[6:2] == OPC_STORE_5)
                && (wb.alu_s2 == IO_CNT_RST);

  // IO reads are latched at the s2 edge to line up with the
  // synchronous DMEM/BIOS read data.
  always_comb begin
    unique case (wb.alu_s2)
      IO_UART_CTRL: io_sel = {30'b0, wb.uart_rx_valid, wb.uart_tx_ready};
      IO_UART_RX:   io_sel = {24'b0, wb.uart_rx_data};
      IO_CYCLE_CNT: io_sel = 32'(cyc_q);
      IO_INST_CNT:  io_sel = 32'(inst_q);
      default:      io_sel = 32'b0;
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    alu_d   = alu_q;
    pc4_d   = pc4_q;
    io_d    = io_q;
    valid_d = valid_q;
    if (wb.flush) begin
      instr_d = NOP_INSTR;
      alu_d   = '0;
      pc4_d   = '0;
      io_d    = '0;
      valid_d = 1'b0;
    end else if (!wb.stall) begin
      instr_d = wb.instr_s2;
      alu_d   = wb.alu_s2;
      pc4_d   = wb.pc4_s2;
      io_d    = io_sel;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    cyc_d  = cyc_q + CNT_W'(1);
    inst_d = retire ? inst_q + CNT_W'(1) : inst_q;
    if (cnt_clr) begin
      cyc_d  = '0;
      inst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      alu_q   <= '0;
      pc4_q   <= '0;
      io_q    <= '0;
      valid_q <= 1'b0;
      cyc_q   <= '0;
      inst_q  <= '0;
    end else begin
      instr_q <= instr_d;
      alu_q   <= alu_d;
      pc4_q   <= pc4_d;
      io_q    <= io_d;
      valid_q <= valid_d;
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    unique case (alu_q[31:28])
      REG_DMEM_A,
      REG_DMEM_B: ld_word = wb.dmem_dout;
      REG_BIOS:   ld_word = wb.bios_dout;
      REG_IO:     ld_word = io_q;
      default:    ld_word = 32'b0;
    endcase
  end

  s3_writeback_load_extract u_ld (
    .word_i  (ld_word),
    .addr_i  (alu_q[1:0]),
    .func3_i (instr_q[14:12]),
    .data_o  (ld_data)
  );

  assign opc = instr_q[6:2];
  assign rd  = instr_q[11:7];

  always_comb begin
    unique case (1'b1)
      (opc == OPC_LOAD_5): wb_sel = WB_MEM;
      (opc == OPC_JAL_5),
      (opc == OPC_JALR_5): wb_sel = WB_PC4;
      default:             wb_sel = WB_ALU;
    endcase
  end

  always_comb begin
    unique case (wb_sel)
      WB_MEM:  wb.wb_data = ld_data;
      WB_PC4:  wb.wb_data = pc4_q;
      default: wb.wb_data = alu_q;
    endcase
  end

  assign wb.wb_we     = valid_q && (rd != 5'd0) && opc_writes_rd(opc);
  assign wb.wb_rd     = rd;
  assign wb.instr_s3  = instr_q;
  assign wb.cycle_cnt = cyc_q;
  assign wb.inst_cnt  = inst_q;

endmodule

// File: tb/tb_s3_writeback.sv
// Directed bench for s3_writeback: a 32-bit instance for the datapath
// and an 8-bit-counter instance for counter wrap.
module tb_s3_writeback;
  import s3_writeback_pkg::*;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] I_LB5   = 32'h0000_0283;
  localparam logic [31:0] I_LH5   = 32'h0000_1283;
  localparam logic [31:0] I_LW5   = 32'h0000_2283;
  localparam logic [31:0] I_LBU5  = 32'h0000_4283;
  localparam logic [31:0] I_LHU5  = 32'h0000_5283;
  localparam logic [31:0] I_JAL1  = 32'h0000_00EF;
  localparam logic [31:0] I_JALR1 = 32'h0000_80E7;
  localparam logic [31:0] I_ADDI0 = 32'h0050_0013;
  localparam logic [31:0] I_ADDI6 = 32'h0000_0313;
  localparam logic [31:0] I_LUI7  = 32'h1234_53B7;
  localparam logic [31:0] I_SW    = 32'h0000_2023;
  localparam logic [31:0] I_BNE   = 32'h0000_1463;

  logic clk;
  logic rst;
  logic rst8;
  int   n_chk;
  int   n_pass;
  int   cyc_exp;
  logic [7:0]  cyc8;
  logic [31:0] smp;

  s3_writeback_if #(.CNT_W(32)) bus ();
  s3_writeback_if #(.CNT_W(8))  bus8 ();

  s3_writeback #(.NOP_INSTR(NOP), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  s3_writeback #(.NOP_INSTR(NOP), .CNT_W(8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .wb  (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) cyc_exp = 0;
    else cyc_exp++;
    if (rst8) cyc8 = 8'd0;
    else cyc8 = cyc8 + 8'd1;
    #1;
  endtask

  task automatic run(input logic [31:0] ins, input logic [31:0] alu,
                     input logic [31:0] pc4, input logic [31:0] dm,
                     input logic [31:0] bi);
    bus.instr_s2 = ins;
    bus.alu_s2   = alu;
    bus.pc4_s2   = pc4;
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;
    tick();
    bus.dmem_dout = dm;
    bus.bios_dout = bi;
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    cyc_exp = 0;
    cyc8 = 8'd0;
    rst = 1'b1;
    rst8 = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    bus.instr_s2 = NOP;
    bus.alu_s2 = '0;
    bus.pc4_s2 = '0;
    bus.dmem_dout = '0;
    bus.bios_dout = '0;
    bus.uart_rx_data = '0;
    bus.uart_rx_valid = 1'b0;
    bus.uart_tx_ready = 1'b0;
    bus8.stall = 1'b0;
    bus8.flush = 1'b1;
    bus8.instr_s2 = NOP;
    bus8.alu_s2 = '0;
    bus8.pc4_s2 = '0;
    bus8.dmem_dout = '0;
    bus8.bios_dout = '0;
    bus8.uart_rx_data = '0;
    bus8.uart_rx_valid = 1'b0;
    bus8.uart_tx_ready = 1'b0;

    tick();
    tick();
    chk("rst_instr", bus.instr_s3, NOP);
    chk("rst_we", 32'(bus.wb_we), 32'd0);
    chk("rst_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_data", bus.wb_data, 32'd0);
    chk("rst_cyc", bus.cycle_cnt, 32'd0);
    chk("rst_inst", bus.inst_cnt, 32'd0);

    rst = 1'b0;
    rst8 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("idle_cyc", bus.cycle_cnt, 32'(i));
    end
    chk("idle_inst", bus.inst_cnt, 32'd0);
    chk("idle_instr", bus.instr_s3, NOP);
    chk("idle_we", 32'(bus.wb_we), 32'd0);

    run(I_ADDI6, 32'd1, 32'd0, 32'd0, 32'd0);
    run(I_ADDI6, 32'd2, 32'd0, 32'd0, 32'd0);
    run(I_ADDI6, 32'd3, 32'd0, 32'd0, 32'd0);
    chk("pipe_data", bus.wb_data, 32'd3);
    chk("pipe_inst", bus.inst_cnt, 32'd2);
    bus.stall = 1'b1;
    bus.instr_s2 = I_ADDI6;
    bus.alu_s2 = 32'd99;
    tick();
    tick();
    chk("stall_instr", bus.instr_s3, I_ADDI6);
    chk("stall_data", bus.wb_data, 32'd3);
    chk("stall_we", 32'(bus.wb_we), 32'd1);
    chk("stall_inst", bus.inst_cnt, 32'd2);
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    tick();
    chk("flush_inst", bus.inst_cnt, 32'd3);
    chk("flush_cyc", bus.cycle_cnt, 32'd9);
    chk("flush_instr", bus.instr_s3, NOP);
    chk("flush_we", 32'(bus.wb_we), 32'd0);

    run(I_LB5, 32'h1000_0003, 32'd0, 32'h80FF_1234, 32'd0);
    chk("lb_data", bus.wb_data, 32'hFFFF_FF80);
    chk("lb_rd", 32'(bus.wb_rd), 32'd5);
    chk("lb_we", 32'(bus.wb_we), 32'd1);
    run(I_LBU5, 32'h1000_0003, 32'd0, 32'h80FF_1234, 32'd0);
    chk("lbu_data", bus.wb_data, 32'h0000_0080);
    run(I_LHU5, 32'h1000_0002, 32'd0, 32'h80FF_1234, 32'd0);
    chk("lhu_data", bus.wb_data, 32'h0000_80FF);
    run(I_LH5, 32'h1000_0003, 32'd0, 32'h80FF_1234, 32'd0);
    chk("lh_data", bus.wb_data, 32'hFFFF_80FF);
    run(I_LBU5, 32'h1000_0000, 32'd0, 32'h80FF_1234, 32'd0);
    chk("lbu0_data", bus.wb_data, 32'h0000_0034);
    run(I_LW5, 32'h1000_0001, 32'd0, 32'h80FF_1234, 32'd0);
    chk("lw_data", bus.wb_data, 32'h80FF_1234);
    run(I_LW5, 32'h3000_0000, 32'd0, 32'h1122_3344, 32'h5566_7788);
    chk("lw_dmemb", bus.wb_data, 32'h1122_3344);
    run(I_LB5, 32'h4000_0001, 32'd0, 32'hDEAD_BEEF, 32'h0000_7F00);
    chk("lb_bios", bus.wb_data, 32'h0000_007F);
    run(I_LW5, 32'h2000_0000, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    chk("lw_unmap", bus.wb_data, 32'd0);

    run(I_JAL1, 32'h1234_5678, 32'h4000_0104, 32'd0, 32'd0);
    chk("jal_data", bus.wb_data, 32'h4000_0104);
    chk("jal_we", 32'(bus.wb_we), 32'd1);
    chk("jal_rd", 32'(bus.wb_rd), 32'd1);
    run(I_JALR1, 32'h0000_0200, 32'h0000_0100, 32'd0, 32'd0);
    chk("jalr_data", bus.wb_data, 32'h0000_0100);
    run(I_ADDI0, 32'd5, 32'd0, 32'd0, 32'd0);
    chk("addi0_we", 32'(bus.wb_we), 32'd0);
    run(I_SW, 32'h1000_0000, 32'd0, 32'd0, 32'd0);
    chk("sw_we", 32'(bus.wb_we), 32'd0);
    run(I_BNE, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("br_we", 32'(bus.wb_we), 32'd0);
    run(I_LUI7, 32'h1234_5000, 32'd0, 32'd0, 32'd0);
    chk("lui_data", bus.wb_data, 32'h1234_5000);
    chk("lui_we", 32'(bus.wb_we), 32'd1);

    bus.uart_rx_valid = 1'b1;
    bus.uart_tx_ready = 1'b0;
    bus.uart_rx_data = 8'hA5;
    run(I_LW5, IO_UART_CTRL, 32'd0, 32'hDEAD_BEEF, 32'd0);
    chk("io_ctrl", bus.wb_data, 32'd2);
    run(I_LBU5, IO_UART_RX, 32'd0, 32'hDEAD_BEEF, 32'd0);
    chk("io_rx", bus.wb_data, 32'h0000_00A5);
    smp = 32'(cyc_exp);
    run(I_LW5, IO_CYCLE_CNT, 32'd0, 32'hDEAD_BEEF, 32'd0);
    chk("io_cyc", bus.wb_data, smp);
    run(I_LW5, 32'h8000_0008, 32'd0, 32'hDEAD_BEEF, 32'd0);
    chk("io_other", bus.wb_data, 32'd0);

    run(I_ADDI6, 32'd7, 32'd0, 32'd0, 32'd0);
    bus.stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    chk("rststall_instr", bus.instr_s3, NOP);
    chk("rststall_we", 32'(bus.wb_we), 32'd0);
    chk("rststall_inst", bus.inst_cnt, 32'd0);
    tick();
    chk("rststall_cyc", bus.cycle_cnt, 32'd1);

    run(I_ADDI6, 32'd9, 32'd0, 32'd0, 32'd0);
    run(I_SW, IO_CNT_RST, 32'd0, 32'd0, 32'd0);
    cyc_exp = 0;
    chk("clr_cyc", bus.cycle_cnt, 32'd0);
    chk("clr_inst", bus.inst_cnt, 32'd0);
    run(I_ADDI6, 32'd1, 32'd0, 32'd0, 32'd0);
    chk("post_clr_cyc", bus.cycle_cnt, 32'd1);
    chk("post_clr_inst", bus.inst_cnt, 32'd1);

    while (cyc8 != 8'hFF) tick();
    chk("wrap_pre", 32'(bus8.cycle_cnt), 32'h0000_00FF);
    tick();
    chk("wrap_post", 32'(bus8.cycle_cnt), 32'd0);
    bus8.flush = 1'b0;
    bus8.instr_s2 = I_ADDI6;
    bus8.alu_s2 = 32'd4;
    tick();
    bus8.instr_s2 = I_SW;
    bus8.alu_s2 = IO_CNT_RST;
    tick();
    chk("w8_clr_cyc", 32'(bus8.cycle_cnt), 32'd0);
    chk("w8_clr_inst", 32'(bus8.inst_cnt), 32'd0);
    bus8.flush = 1'b1;
    tick();
    chk("w8_post_cyc", 32'(bus8.cycle_cnt), 32'd1);
    chk("w8_post_inst", 32'(bus8.inst_cnt), 32'd1);
    chk("cyc_model", bus.cycle_cnt, 32'(cyc_exp));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
